mult_rr_scheduler: RTL
======================

// Module: mult_rr_scheduler
// PURPOSE
//   Shares one shift-add Multiplier (start/M/Qin in, 2N-bit AQ out) between R requesters.
//   - Round-robin arbitration; one operation in flight at a time.
//   - Drives the multiplier's start pulse and operands, waits a fixed latency, then captures AQ.
//   - Returns each product on a valid/ready response channel, tagged with the requester id.
// PARAMETERS
//   N        4        operand width; product width is 2*N
//   R        4        number of requesters, >=2; ID width IW = $clog2(R)
//   LATENCY  2*N+1    cycles from the mul_start cycle to the cycle mul_aq is sampled, >=1
// PORTS
//   clock        in   1      single clock, rising edge
//   n_reset      in   1      asynchronous, active-low reset
//   req_valid    in   R      per-requester request valid
//   req_ready    out  R      per-requester accept, one-hot or zero
//   req_m        in   R*N    multiplicands; slice i = [i*N +: N]
//   req_q        in   R*N    multipliers; slice i = [i*N +: N]
//   rsp_valid    out  1      product valid
//   rsp_ready    in   1      downstream accepts product
//   rsp_id       out  IW     index of the requester that owns rsp_product
//   rsp_product  out  2*N    unsigned product
//   mul_start    out  1      to Multiplier.start
//   mul_m        out  N      to Multiplier.M
//   mul_q        out  N      to Multiplier.Qin
//   mul_aq       in   2*N    from Multiplier.AQ
// BEHAVIOUR
//   Reset (n_reset low, async): state IDLE, rr pointer 0.
//     - All outputs 0: req_ready, rsp_valid, rsp_id, rsp_product, mul_start, mul_m, mul_q.
//     - Any in-flight operation is dropped.
//   FSM: IDLE -> START -> RUN -> DONE -> IDLE.
//   IDLE: grant g is the first i with req_valid[i] set, searching upward from the rr pointer with wrap.
//     - req_ready[g] = 1, combinational, only in IDLE. All other req_ready bits are 0.
//     - On req_valid[g] && req_ready[g] (accept cycle c0): latch req_m[g], req_q[g] and g; go to START.
//     - With no req_valid bits set, stay in IDLE and leave the pointer unchanged.
//     - A req_valid that drops before it is granted has no effect.
//   START (cycle c1): mul_start = 1 for exactly this cycle; load the counter with LATENCY; go to RUN.
//   RUN (cycles c2..c(LATENCY+1)): decrement the counter each cycle.
//     - At the end of cycle c(LATENCY+1), capture mul_aq into rsp_product; go to DONE.
//   mul_m / mul_q: drive the latched operands from c1 through the capture cycle.
//     - They never change mid-operation.
//     - They return to 0 in IDLE.
//   DONE (from c(LATENCY+2)): rsp_valid = 1; rsp_id and rsp_product are held stable.
//     - On rsp_ready: set the pointer to (g+1) mod R, then go to IDLE.
//     - Backpressure: DONE holds indefinitely. No req_ready is raised and mul_start stays 0.
//   Timing:
//     - Accept-to-rsp_valid latency is LATENCY+2 cycles.
//     - Best-case issue interval is LATENCY+3 cycles, with rsp_ready held high.
//   Width: rsp_product = mul_aq, all 2*N bits, unsigned, no truncation. 15*15 = 225 fits in 8 bits for N=4.
//   Simultaneous requests are all served in rr order. Requests that lose arbitration stay pending.
// CONFIGURATION
//   MULT_RR_ZERO_BYPASS_EN defined:
//     - An accepted request with latched M==0 or Q==0 skips START and RUN.
//     - It goes IDLE -> DONE with rsp_product = 0.
//     - rsp_valid rises at c1 and mul_start stays 0 for that operation.
//   MULT_RR_ZERO_BYPASS_EN undefined: every request uses the multiplier with the full LATENCY+2 latency.
// TESTING  (N=4, R=4, LATENCY=9; accept cycle = c0)
//   1. Single request, ch2, M=5, Q=3, rsp_ready=1:
//      req_ready[2] in c0; mul_start only in c1; rsp_valid in c11 with rsp_id=2, rsp_product=0x0F.
//   2. All four req_valid held high from reset release:
//      grants in order 0,1,2,3,0; exactly one req_ready bit per IDLE cycle.
//   3. ch1, M=15, Q=15, rsp_ready low for 5 cycles after rsp_valid:
//      rsp_product=0xE1 stays stable; req_ready=0 and mul_start=0 throughout; back to IDLE the cycle after rsp_ready.
//   4. n_reset pulsed low during RUN (c5):
//      all outputs 0 immediately. After release with all req_valid high, ch0 is granted first and no stale response appears.
//   5. ch3, M=0, Q=9:
//      with MULT_RR_ZERO_BYPASS_EN, rsp_valid in c1 with product 0 and mul_start never high.
//      without it, rsp_valid in c11 with product 0.
//   6. ch0 and ch3 valid, pointer=3:
//      ch3 granted first, then ch0; pointer=1 after ch0's response.

Source files
------------

// File: rtl/mult_rr_scheduler.sv
// ---------------------------------------------------------------------------
// mult_rr_scheduler
//
// Purpose:
//   Shares one shift-add multiplier between R requesters. Requests are
//   granted round-robin, one operation is in flight at a time, and each
//   product is returned on a valid/ready channel tagged with the id of the
//   requester that asked for it.
//
// Ports:
//   clock        in   1      rising-edge clock
//   n_reset      in   1      asynchronous, active-low reset
//   req_valid    in   R      per-requester request valid
//   req_ready    out  R      per-requester accept (one-hot or zero, IDLE only)
//   req_m        in   R*N    multiplicands, slice i = [i*N +: N]
//   req_q        in   R*N    multipliers,   slice i = [i*N +: N]
//   rsp_valid    out  1      product valid
//   rsp_ready    in   1      downstream accepts product
//   rsp_id       out  IW     requester that owns rsp_product
//   rsp_product  out  2*N    unsigned product
//   mul_start    out  1      one-cycle start pulse to the multiplier
//   mul_m        out  N      multiplier M operand
//   mul_q        out  N      multiplier Qin operand
//   mul_aq       in   2*N    multiplier AQ result
//
// Configuration:
//   MULT_RR_ZERO_BYPASS_EN  when defined, a request whose M or Q is zero
//                           skips the multiplier and answers 0 one cycle
//                           after acceptance.
// ---------------------------------------------------------------------------
module mult_rr_scheduler #(
  parameter  int N       = 4,
  parameter  int R       = 4,
  parameter  int LATENCY = 2*N+1,
  localparam int IW      = $clog2(R)
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic [R-1:0]      req_valid,
  output logic [R-1:0]      req_ready,
  input  logic [R*N-1:0]    req_m,
  input  logic [R*N-1:0]    req_q,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IW-1:0]     rsp_id,
  output logic [2*N-1:0]    rsp_product,
  output logic              mul_start,
  output logic [N-1:0]      mul_m,
  output logic [N-1:0]      mul_q,
  input  logic [2*N-1:0]    mul_aq
);

  localparam int CW = $clog2(LATENCY+1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t          r_state;
  state_t          w_nextState;

  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_id;
  logic [IW-1:0]   r_rspId;
  logic [N-1:0]    r_m;
  logic [N-1:0]    r_q;
  logic [2*N-1:0]  r_product;
  logic [CW-1:0]   r_count;

  logic [IW-1:0]   w_grant;
  logic            w_grantValid;
  logic            w_accept;
  logic            w_capture;
  logic [N-1:0]    w_grantM;
  logic [N-1:0]    w_grantQ;
  int              w_sum;
  logic [IW-1:0]   w_cand;

  // Round-robin search: walk downward from the farthest candidate so the
  // last hit written is the one closest to the pointer. The wrap is done by
  // subtraction so R need not be a power of two.
  always_comb begin
    w_grant      = '0;
    w_grantValid = 1'b0;
    w_sum        = 0;
    w_cand       = '0;
    for (int k = R-1; k >= 0; k--) begin
      w_sum = int'(r_ptr) + k;
      if (w_sum >= R) begin
        w_sum = w_sum - R;
      end
      w_cand = IW'(w_sum);
      if (req_valid[w_cand]) begin
        w_grant      = w_cand;
        w_grantValid = 1'b1;
      end
    end
  end

  assign w_grantM  = req_m[w_grant*N +: N];
  assign w_grantQ  = req_q[w_grant*N +: N];
  assign w_accept  = (r_state == ST_IDLE) && w_grantValid;
  // The counter holds 1 in the last RUN cycle, which is the cycle the
  // multiplier result is valid.
  assign w_capture = (r_state == ST_RUN) && (r_count == CW'(1));

  // State register.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and handshake outputs. req_ready is also qualified by
  // n_reset so that nothing is offered while reset is held, even though
  // the state register already sits in IDLE.
  always_comb begin
    w_nextState = r_state;
    req_ready   = '0;
    mul_start   = 1'b0;
    rsp_valid   = 1'b0;
    mul_m       = '0;
    mul_q       = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_grantValid && n_reset) begin
          req_ready = R'(1) << w_grant;
        end
        if (w_accept) begin
`ifdef MULT_RR_ZERO_BYPASS_EN
          if ((w_grantM == '0) || (w_grantQ == '0)) begin
            w_nextState = ST_DONE;
          end else begin
            w_nextState = ST_START;
          end
`else
          w_nextState = ST_START;
`endif
        end
      end
      ST_START: begin
        mul_start   = 1'b1;
        mul_m       = r_m;
        mul_q       = r_q;
        w_nextState = ST_RUN;
      end
      ST_RUN: begin
        mul_m = r_m;
        mul_q = r_q;
        if (w_capture) begin
          w_nextState = ST_DONE;
        end
      end
      ST_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_nextState = ST_IDLE;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Datapath: operand latch, latency counter, result capture and the
  // round-robin pointer, which only advances once a response is taken.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_ptr     <= '0;
      r_id      <= '0;
      r_rspId   <= '0;
      r_m       <= '0;
      r_q       <= '0;
      r_product <= '0;
      r_count   <= '0;
    end else begin
      if (w_accept) begin
        r_id <= w_grant;
        r_m  <= w_grantM;
        r_q  <= w_grantQ;
`ifdef MULT_RR_ZERO_BYPASS_EN
        if ((w_grantM == '0) || (w_grantQ == '0)) begin
          r_product <= '0;
          r_rspId   <= w_grant;
        end
`endif
      end
      if (r_state == ST_START) begin
        r_count <= CW'(LATENCY);
      end else if (r_state == ST_RUN) begin
        r_count <= r_count - CW'(1);
      end
      if (w_capture) begin
        r_product <= mul_aq;
        r_rspId   <= r_id;
      end
      if ((r_state == ST_DONE) && rsp_ready) begin
        if (r_id == IW'(R-1)) begin
          r_ptr <= '0;
        end else begin
          r_ptr <= r_id + 1'b1;
        end
      end
    end
  end

  assign rsp_id      = r_rspId;
  assign rsp_product = r_product;

endmodule
